// File: rtl/spike_event_tx.sv
// -----------------------------------------------------------------------------
// spike_event_tx
//
// Purpose:
//   Buffers spike events from the neuron array ({timestamp, neuron address})
//   in a small circular FIFO and drains them, one whole event at a time, to
//   the byte-wide UART transmitter. Each event is zero-extended to a whole
//   number of bytes and sent MSB-first. Each byte is started with a one-cycle
//   tx_dv strobe, and the block waits for tx_done before starting the next one.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       asynchronous, active-high reset
//   en          write enable; sp_in is ignored while low (draining continues)
//   sp_in       spike valid, at most one event per cycle
//   sp_data     event word {ts[TS_WID-1:0], addr[AW-1:0]}
//   tx_done     one-cycle pulse from the UART when a byte has finished
//   tx_dv       one-cycle start strobe to the UART
//   tx_byte     byte to send (held stable while the UART is busy with it)
//   fifo_full   FIFO holds FIFO_DEPTH events
//   fifo_empty  FIFO holds no events
//   drop_cnt    saturating count of events rejected because the FIFO was full
//   busy        serialiser is not idle
// -----------------------------------------------------------------------------
module spike_event_tx #(
   parameter int NEURON_NO  = 3072,
   parameter int TS_WID     = 12,
   parameter int FIFO_DEPTH = 8,   // power of two, at least 2
   parameter int OUT_W      = 8,
   localparam int AW        = $clog2(NEURON_NO),
   localparam int EV_W      = TS_WID + AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sp_in,
   input  logic [EV_W-1:0]  sp_data,
   input  logic             tx_done,
   output logic             tx_dv,
   output logic [OUT_W-1:0] tx_byte,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic [15:0]      drop_cnt,
   output logic             busy
);

   // Bytes per event and the width of the zero-extended serialiser word.
   localparam int NB    = (EV_W + OUT_W - 1) / OUT_W;
   localparam int SR_W  = NB * OUT_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT
   } state_t;

   // ---------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ---------------------------------------------------------------------
   logic [EV_W-1:0]  mem_reg [FIFO_DEPTH];
   logic [EV_W-1:0]  head_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             fifo_full_reg;
   logic             fifo_empty_reg;
   logic [15:0]      drop_cnt_reg;

   logic             push_req;
   logic             push_ok;
   logic             pop;

   // ---------------------------------------------------------------------
   // Serialiser state
   // ---------------------------------------------------------------------
   state_t           state_reg;
   logic [SR_W-1:0]  shift_reg;
   logic [SR_W-1:0]  shift_next;
   logic [SR_W-1:0]  head_ext;
   logic [IDX_W-1:0] idx_reg;
   logic             tx_dv_reg;
   logic [OUT_W-1:0] tx_byte_reg;
   logic             busy_reg;

   // A pop only ever happens from IDLE with something stored. Because the
   // pop frees a slot on the same edge, a push into a full FIFO is still
   // accepted in that cycle.
   always_comb begin
      pop        = (state_reg == IDLE) && !fifo_empty_reg;
      push_req   = en && sp_in;
      push_ok    = push_req && ((count_reg < CNT_W'(FIFO_DEPTH)) || pop);
      count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
      head_ext   = SR_W'(head_reg);
      shift_next = shift_reg << OUT_W;
   end

   // Storage array kept free of reset so it maps onto block RAM. The head
   // is read into a register on the pop edge; the FSM consumes it in LOAD.
   // When a push and pop hit the same slot (full FIFO), the read returns
   // the old entry, which is the one being popped.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= sp_data;
      end
      if (pop) begin
         head_reg <= mem_reg[rd_ptr_reg];
      end
   end

   // Pointers wrap naturally at FIFO_DEPTH since the depth is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         fifo_empty_reg <= 1'b1;
         fifo_full_reg  <= 1'b0;
         drop_cnt_reg   <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg      <= count_next;
         fifo_empty_reg <= (count_next == '0);
         fifo_full_reg  <= (count_next == CNT_W'(FIFO_DEPTH));
         if (push_req && !push_ok && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Serialiser FSM. tx_dv is raised on the edge that enters SEND so that
   // the strobe is high exactly for the SEND cycle; tx_byte changes only
   // on those same edges and is therefore stable through WAIT.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         idx_reg     <= '0;
         tx_dv_reg   <= 1'b0;
         tx_byte_reg <= '0;
         busy_reg    <= 1'b0;
      end else begin
         tx_dv_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  state_reg <= LOAD;
                  busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               shift_reg   <= head_ext;
               idx_reg     <= '0;
               tx_byte_reg <= head_ext[SR_W-1 -: OUT_W];
               tx_dv_reg   <= 1'b1;
               state_reg   <= SEND;
            end
            SEND: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (idx_reg == IDX_W'(NB - 1)) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     shift_reg   <= shift_next;
                     idx_reg     <= idx_reg + IDX_W'(1);
                     tx_byte_reg <= shift_next[SR_W-1 -: OUT_W];
                     tx_dv_reg   <= 1'b1;
                     state_reg   <= SEND;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_dv      = tx_dv_reg;
   assign tx_byte    = tx_byte_reg;
   assign fifo_full  = fifo_full_reg;
   assign fifo_empty = fifo_empty_reg;
   assign drop_cnt   = drop_cnt_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_spike_event_tx.sv
// -----------------------------------------------------------------------------
// tb_spike_event_tx
//
// Bench for spike_event_tx at default parameters (24-bit events, 3 bytes,
// 8-entry FIFO). A queue-based reference model predicts every registered
// output each cycle from the push/pop and handshake timing rules; directed
// sequences add literal expectations for latency, drop counting, full+pop,
// en gating, asynchronous reset and pointer wrap.
// -----------------------------------------------------------------------------
module tb_spike_event_tx;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        sp_in = 1'b0;
   logic [23:0] sp_data = '0;
   logic        tx_done = 1'b0;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        fifo_full;
   logic        fifo_empty;
   logic [15:0] drop_cnt;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;

   spike_event_tx dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .sp_in      (sp_in),
      .sp_data    (sp_data),
      .tx_done    (tx_done),
      .tx_dv      (tx_dv),
      .tx_byte    (tx_byte),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: FIFO contents as a queue, the event being sent as a
   // queue of remaining bytes, and the handshake latencies.
   // ---------------------------------------------------------------------
   logic [23:0] m_q[$];
   logic [7:0]  m_bytes[$];
   bit          m_busy = 0;
   bit          m_dv = 0;
   bit          m_wait = 0;
   int          m_lead = 0;
   logic [7:0]  m_byte = '0;
   int          m_drop = 0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_q.delete();
         m_bytes.delete();
         m_busy = 0;
         m_dv   = 0;
         m_wait = 0;
         m_lead = 0;
         m_byte = '0;
         m_drop = 0;
      end else begin
         bit          pop;
         bit          acc;
         bit          nxt_dv;
         logic [23:0] ev;
         nxt_dv = 0;
         pop = !m_busy && (m_q.size() != 0);
         if (m_busy) begin
            if (m_lead > 0) begin
               m_lead--;
               if (m_lead == 0) begin
                  nxt_dv = 1;
                  m_byte = m_bytes[0];
               end
            end else if (m_dv) begin
               m_wait = 1;
            end else if (m_wait && tx_done) begin
               m_wait = 0;
               void'(m_bytes.pop_front());
               if (m_bytes.size() == 0) begin
                  m_busy = 0;
               end else begin
                  nxt_dv = 1;
                  m_byte = m_bytes[0];
               end
            end
         end
         acc = en && sp_in && ((m_q.size() < DEPTH) || pop);
         if (pop) begin
            ev      = m_q.pop_front();
            m_bytes = {ev[23:16], ev[15:8], ev[7:0]};
            m_busy  = 1;
            m_lead  = 1;
         end
         if (en && sp_in) begin
            if (acc) m_q.push_back(sp_data);
            else if (m_drop < 'hFFFF) m_drop++;
         end
         m_dv = nxt_dv;
      end
   end

   // Per-cycle comparison against the model; also logs every sent byte.
   logic [7:0] mon[$];

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("tx_dv", tx_dv, m_dv);
         chk("tx_byte", tx_byte, m_byte);
         chk("busy", busy, m_busy);
         chk("fifo_empty", fifo_empty, m_q.size() == 0);
         chk("fifo_full", fifo_full, m_q.size() == DEPTH);
         chk("drop_cnt", drop_cnt, m_drop);
         if (tx_dv) mon.push_back(tx_byte);
      end
   end

   // ---------------------------------------------------------------------
   // UART stand-in: answers each tx_dv with a tx_done after a fixed or
   // random delay, or emits manual pulses requested by the main sequence.
   // ---------------------------------------------------------------------
   int pend = -1;
   bit resp_en = 0;
   bit rand_mode = 0;
   int fix_delay = 10;
   int stray_req = 0;
   int stray_done = 0;

   initial forever begin
      @(posedge clk);
      #2;
      tx_done = 1'b0;
      if (reset) begin
         pend = -1;
      end else begin
         if (stray_req != stray_done) begin
            tx_done = 1'b1;
            stray_done++;
         end else if (pend == 0) begin
            tx_done = 1'b1;
            pend = -1;
         end else if (pend > 0) begin
            pend--;
         end
         if (tx_dv && resp_en)
            pend = (rand_mode ? int'($urandom_range(30, 1)) : fix_delay) - 1;
      end
   end

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   logic [7:0] exp_b[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [23:0] d);
      sp_data = d;
      sp_in   = 1'b1;
      tick();
      sp_in   = 1'b0;
   endtask

   task automatic pulse();
      stray_req++;
   endtask

   task automatic add_ev(input logic [23:0] e);
      exp_b.push_back(e[23:16]);
      exp_b.push_back(e[15:8]);
      exp_b.push_back(e[7:0]);
   endtask

   task automatic wait_dv(input string nm);
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         seen = tx_dv;
      end
      chk({nm, "_dv_seen"}, seen, 1);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      bit idle = 0;
      for (int i = 0; i < budget && !idle; i++) begin
         tick();
         idle = fifo_empty && !busy;
      end
      chk({nm, "_idle"}, idle, 1);
   endtask

   task automatic check_stream(input string nm, input int mark);
      chk({nm, "_len"}, mon.size() - mark, exp_b.size());
      for (int i = 0; i < exp_b.size() && (mark + i) < mon.size(); i++)
         chk($sformatf("%s_b%0d", nm, i), mon[mark + i], exp_b[i]);
   endtask

   function automatic logic [23:0] burst_ev(input int i);
      return 24'h102030 + 24'(i) * 24'h050301;
   endfunction

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   initial begin
      int mark;

      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_on = 1;

      // Reset state
      chk("rst_tx_dv", tx_dv, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_drop", drop_cnt, 0);

      // Single event, 10-cycle UART
      fix_delay = 10;
      resp_en   = 1;
      en        = 1'b1;
      sp_data   = 24'h00A005;
      sp_in     = 1'b1;
      tick();
      sp_in = 1'b0;
      chk("t1_c1_empty", fifo_empty, 0);
      tick();
      chk("t1_c2_tx_dv", tx_dv, 0);
      chk("t1_c2_busy", busy, 1);
      tick();
      chk("t1_c3_tx_dv", tx_dv, 1);
      chk("t1_c3_byte0", tx_byte, 8'h00);
      wait_dv("t1_b1");
      chk("t1_byte1", tx_byte, 8'hA0);
      wait_dv("t1_b2");
      chk("t1_byte2", tx_byte, 8'h05);
      repeat (10) tick();
      chk("t1_busy_at_done", busy, 1);
      tick();
      chk("t1_busy_after_done", busy, 0);
      repeat (3) tick();

      // Burst of 10 with the UART stalled: 9 accepted, 1 dropped
      resp_en = 0;
      mark = mon.size();
      for (int i = 0; i < 10; i++) push(burst_ev(i));
      tick();
      chk("t2_drop", drop_cnt, 1);
      chk("t2_full", fifo_full, 1);
      chk("t2_busy", busy, 1);

      // Finish event 0 by hand, then push into the full FIFO on the pop cycle
      pulse();
      wait_dv("t3_b1");
      tick();
      pulse();
      wait_dv("t3_b2");
      tick();
      pulse();
      tick();
      chk("t3_idle_busy", busy, 0);
      chk("t3_idle_full", fifo_full, 1);
      sp_data = burst_ev(10);
      sp_in   = 1'b1;
      tick();
      sp_in = 1'b0;
      chk("t3_full_kept", fifo_full, 1);
      chk("t3_drop_kept", drop_cnt, 1);
      chk("t3_busy", busy, 1);
      fix_delay = 3;
      resp_en   = 1;
      wait_idle("t3_drain", 3000);
      exp_b.delete();
      for (int i = 0; i < 9; i++) add_ev(burst_ev(i));
      add_ev(burst_ev(10));
      check_stream("t3_stream", mark);

      // en low: sp_in ignored while a transmission completes
      fix_delay = 10;
      mark = mon.size();
      push(24'h7E5123);
      wait_dv("t4_b0");
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sp_data = 24'hABC000 + 24'(i);
         sp_in   = (i % 2 == 0);
         tick();
      end
      sp_in = 1'b0;
      en    = 1'b1;
      wait_idle("t4", 500);
      chk("t4_drop", drop_cnt, 1);
      chk("t4_empty", fifo_empty, 1);
      exp_b.delete();
      add_ev(24'h7E5123);
      check_stream("t4_stream", mark);

      // Asynchronous reset while waiting after byte 1
      push(24'hC35A96);
      push(24'h0F0F0F);
      wait_dv("t5_b0");
      wait_dv("t5_b1");
      tick();
      tick();
      #3 reset = 1'b1;
      #1;
      chk("t5_tx_dv", tx_dv, 0);
      chk("t5_tx_byte", tx_byte, 0);
      chk("t5_busy", busy, 0);
      chk("t5_empty", fifo_empty, 1);
      chk("t5_full", fifo_full, 0);
      chk("t5_drop", drop_cnt, 0);
      @(posedge clk);
      #3 reset = 1'b0;
      mark = mon.size();
      repeat (20) tick();
      chk("t5_no_dv", mon.size() - mark, 0);
      chk("t5_busy_after", busy, 0);

      // 20 events through the FIFO with random UART delay
      rand_mode = 1;
      resp_en   = 1;
      mark      = mon.size();
      exp_b.delete();
      for (int i = 0; i < 20; i++) begin
         logic [23:0] ev;
         ev = {12'(i * 37 + 5), 12'(i * 101 + 3)};
         for (int k = 0; k < 200 && fifo_full; k++) tick();
         push(ev);
         add_ev(ev);
      end
      wait_idle("t6", 6000);
      check_stream("t6_stream", mark);
      chk("t6_drop", drop_cnt, 0);

      // Stray tx_done pulses in IDLE
      resp_en = 0;
      mark = mon.size();
      repeat (5) begin
         pulse();
         tick();
         tick();
      end
      repeat (5) tick();
      chk("t6_stray_no_dv", mon.size() - mark, 0);
      chk("t6_stray_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "time limit");
   end

endmodule
